// File: rtl/cd40xx_gate_bank.sv
// Bank of registered, synchronised, stability-filtered CMOS-style gates.
// Optional per-channel change counters when GATE_BANK_EDGE_CNT_EN is defined.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   a         in   CHANNELS*INPUTS async gate inputs (ch c at [c*INPUTS +: INPUTS])
//   mode      in   3*CHANNELS function select (ch c at [3c +: 3])
//   filt_len  in   FILT_W stable-edge count before an output change (0 acts as 1)
//   y         out  CHANNELS filtered outputs
//   changed   out  CHANNELS one-cycle update pulses
//   clr_cnt   in   (GATE_BANK_EDGE_CNT_EN) synchronous clear of edge_cnt
//   edge_cnt  out  (GATE_BANK_EDGE_CNT_EN) 8*CHANNELS wrapping change counters
module cd40xx_gate_bank #(
  parameter int CHANNELS    = 3,
  parameter int INPUTS      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*INPUTS-1:0]   a,
  input  logic [3*CHANNELS-1:0]        mode,
  input  logic [FILT_W-1:0]            filt_len,
  output logic [CHANNELS-1:0]          y,
  output logic [CHANNELS-1:0]          changed
`ifdef GATE_BANK_EDGE_CNT_EN
  ,
  input  logic                         clr_cnt,
  output logic [8*CHANNELS-1:0]        edge_cnt
`endif
);

  localparam logic [FILT_W-1:0] ONE = FILT_W'(1);

  logic [CHANNELS*INPUTS-1:0] r_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0]     r_vld;
  logic [CHANNELS*INPUTS-1:0] w_s;
  logic [FILT_W-1:0]          w_flim;

  // r_vld tracks how far real samples have filled the sync chain,
  // so the filter never counts reset-state zeros as a stable input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        r_sync[i] <= '0;
      r_vld <= '0;
    end else begin
      r_sync[0] <= a;
      r_vld[0]  <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Last count value before an update: F-1, with filt_len=0 acting as F=1.
  assign w_flim = (filt_len == '0) ? '0 : filt_len - ONE;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [INPUTS-1:0] w_grp;
    logic [2:0]        w_m;
    logic              w_raw;
    logic              w_hold;
    logic [FILT_W-1:0] r_cnt;
    logic              r_y;
    logic              r_chg;

    assign w_grp = w_s[c*INPUTS +: INPUTS];
    assign w_m   = mode[3*c +: 3];

    always_comb begin
      w_raw  = 1'b0;
      w_hold = 1'b0;
      unique case (w_m)
        3'b000: w_raw = &w_grp;
        3'b001: w_raw = ~&w_grp;
        3'b010: w_raw = |w_grp;
        3'b011: w_raw = ~|w_grp;
        3'b100: w_raw = ^w_grp;
        3'b101: w_raw = ~^w_grp;
        3'b110: w_hold = 1'b1;
        3'b111: w_hold = 1'b1;
        default: w_hold = 1'b1;
      endcase
    end

    // Single-bit output: a mismatch always means the opposite level,
    // so a run counter is enough and any agreement restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_y   <= 1'b0;
        r_chg <= 1'b0;
      end else if (w_hold || !r_vld[SYNC_STAGES-1] || (w_raw == r_y)) begin
        r_cnt <= '0;
        r_chg <= 1'b0;
      end else if (r_cnt >= w_flim) begin
        r_y   <= w_raw;
        r_cnt <= '0;
        r_chg <= 1'b1;
      end else begin
        r_cnt <= r_cnt + ONE;
        r_chg <= 1'b0;
      end
    end

    assign y[c]       = r_y;
    assign changed[c] = r_chg;

`ifdef GATE_BANK_EDGE_CNT_EN
    logic [7:0] r_ecnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_ecnt <= '0;
      else if (clr_cnt)
        r_ecnt <= '0;
      else if (r_chg)
        r_ecnt <= r_ecnt + 8'd1;
    end

    assign edge_cnt[8*c +: 8] = r_ecnt;
`endif
  end

endmodule

// File: tb/tb_cd40xx_gate_bank.sv
// Self-checking bench for cd40xx_gate_bank: vector table,
// hand-written corner sequences and a randomised model comparison.
module tb_cd40xx_gate_bank;

  localparam int CH = 3;
  localparam int IN = 3;
  localparam int SS = 2;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          clk_en = 1'b1;
  logic          rst_n = 1'b0;
  logic [8:0]    a = '0;
  logic [8:0]    mode = '0;
  logic [FW-1:0] filt_len = '0;
  logic [2:0]    y;
  logic [2:0]    changed;
`ifdef GATE_BANK_EDGE_CNT_EN
  logic          clr_cnt = 1'b0;
  logic [23:0]   edge_cnt;
`endif

  always #5 if (clk_en) clk = ~clk;

  cd40xx_gate_bank #(
    .CHANNELS(CH), .INPUTS(IN),
    .SYNC_STAGES(SS), .FILT_W(FW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .mode(mode),
    .filt_len(filt_len),
    .y(y),
    .changed(changed)
`ifdef GATE_BANK_EDGE_CNT_EN
    ,
    .clr_cnt(clr_cnt),
    .edge_cnt(edge_cnt)
`endif
  );

  int pass_n = 0;
  int total_n = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: history of sampled inputs plus run lengths.
  logic [8:0] m_hist[$];
  logic [2:0] m_y;
  logic [2:0] m_chg;
  int         m_run[3];

  function automatic logic [1:0] gate_ref(input logic [2:0] m,
                                          input logic [2:0] v);
    int ones;
    ones = $countones(v);
    case (m)
      3'd0: return {1'b0, ones == 3};
      3'd1: return {1'b0, ones != 3};
      3'd2: return {1'b0, ones != 0};
      3'd3: return {1'b0, ones == 0};
      3'd4: return {1'b0, (ones % 2) == 1};
      3'd5: return {1'b0, (ones % 2) == 0};
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_y = '0;
    m_chg = '0;
    for (int c = 0; c < 3; c++) m_run[c] = 0;
  endtask

  task automatic model_edge();
    logic [8:0] s;
    logic [1:0] hr;
    int f;
    bit ok;
    m_hist.push_front(a);
    if (m_hist.size() > SS + 1) void'(m_hist.pop_back());
    ok = (m_hist.size() > SS);
    s = ok ? m_hist[SS] : '0;
    f = (filt_len == 0) ? 1 : int'(filt_len);
    for (int c = 0; c < 3; c++) begin
      hr = gate_ref(mode[3*c +: 3], s[3*c +: 3]);
      m_chg[c] = 1'b0;
      if (!ok || hr[1] || hr[0] == m_y[c]) begin
        m_run[c] = 0;
      end else if (m_run[c] + 1 >= f) begin
        m_y[c] = hr[0];
        m_run[c] = 0;
        m_chg[c] = 1'b1;
      end else begin
        m_run[c]++;
      end
    end
  endtask

  typedef struct {
    logic [2:0] m;
    logic [8:0] a;
    logic [2:0] y;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [2:0] acc;
    logic [2:0] yhold;
    bit found;

    vecs[0] = '{3'b000, 9'b111_011_000, 3'b100};
    vecs[1] = '{3'b001, 9'b111_011_000, 3'b011};
    vecs[2] = '{3'b010, 9'b000_001_100, 3'b011};
    vecs[3] = '{3'b011, 9'b000_001_100, 3'b100};
    vecs[4] = '{3'b100, 9'b111_110_100, 3'b101};
    vecs[5] = '{3'b101, 9'b111_110_100, 3'b010};
    vecs[6] = '{3'b110, 9'b000_000_000, 3'b010};
    vecs[7] = '{3'b111, 9'b111_111_111, 3'b010};

    // Reset held, then released with AND and a=0.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("reset_hold", {y, changed}, 6'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("and_zero", {y, changed}, 6'b0);
    end

    // Function table, F=1.
    for (int i = 0; i < 8; i++) begin
      mode = {3{vecs[i].m}};
      a = vecs[i].a;
      for (int k = 0; k < 8; k++) tick();
      chk($sformatf("table_y[%0d]", i), y, vecs[i].y);
      chk($sformatf("table_chg[%0d]", i), changed, 3'b0);
    end

    // Asynchronous clear with the clock stopped.
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #3;
    chk("async_clr_y", y, 3'b0);
    #20;
    chk("async_clr_hold", {y, changed}, 6'b0);
    mode = '0;
    a = '0;
    clk_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // Latency with filt_len=0 on ch0 AND.
    for (int i = 0; i < 4; i++) tick();
    a = 9'b000_000_111;
    tick();
    chk("lat_e1", y, 3'b000);
    tick();
    chk("lat_e2", y, 3'b000);
    tick();
    chk("lat_e3_y", y, 3'b001);
    chk("lat_e3_chg", changed, 3'b001);
    tick();
    chk("lat_e4_chg", changed, 3'b000);

    // Pulse rejection with F=4 on ch1 OR.
    a = '0;
    for (int i = 0; i < 6; i++) tick();
    chk("pulse_pre", y, 3'b000);
    filt_len = 4'd4;
    mode = 9'b000_010_000;
    a = 9'b000_001_000;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acc |= changed | y;
    end
    a = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc |= changed | y;
    end
    chk("pulse_reject", acc, 3'b000);
    a = 9'b000_001_000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("f4_wait", y, 3'b000);
    end
    tick();
    chk("f4_e6_y", y, 3'b010);
    chk("f4_e6_chg", changed, 3'b010);
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc |= changed;
    end
    chk("f4_one_pulse", acc, 3'b000);

    // XOR on ch2 with F=1, then HOLD.
    filt_len = 4'd1;
    mode = 9'b100_000_000;
    a = 9'b111_000_000;
    for (int i = 0; i < 4; i++) tick();
    chk("xor_111", y[2], 1'b1);
    a = 9'b011_000_000;
    for (int i = 0; i < 4; i++) tick();
    chk("xor_011", y[2], 1'b0);
    a = 9'b111_000_000;
    for (int i = 0; i < 4; i++) tick();
    chk("xor_back", y[2], 1'b1);
    mode = 9'b110_000_000;
    yhold = y;
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      a[8:6] = 3'($urandom_range(0, 7));
      tick();
      acc[0] |= (y[2] != yhold[2]);
      acc[1] |= changed[2];
    end
    chk("hold_frozen", acc[0], 1'b0);
    chk("hold_nochg", acc[1], 1'b0);

    // Reset mid-count, then full latency from reset.
    rst_n = 1'b0;
    a = '0;
    mode = 9'b000_000_001;
    filt_len = 4'd8;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("nand_cnt5", y, 3'b000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {y, changed}, 6'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("nand_wait", y[0], 1'b0);
    end
    tick();
    chk("nand_e10_y", y, 3'b001);
    chk("nand_e10_chg", changed, 3'b001);
    tick();
    chk("nand_e11_chg", changed, 3'b000);

    // Random stimulus against the model.
    rst_n = 1'b0;
    #1;
    tick();
    model_reset();
    mode = '0;
    a = '0;
    filt_len = 4'd2;
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("rand", {y, changed}, {m_y, m_chg});
      if ($urandom_range(0, 3) == 0) begin
        int idx;
        idx = $urandom_range(0, 8);
        a[idx] = ~a[idx];
      end
      if ($urandom_range(0, 49) == 0) begin
        int ch;
        ch = $urandom_range(0, 2);
        mode[3*ch +: 3] = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 99) == 0)
        filt_len = FW'($urandom_range(0, 5));
    end

`ifdef GATE_BANK_EDGE_CNT_EN
    // Edge counter wrap and clear priority.
    filt_len = '0;
    mode = 9'b110_110_100;
    a = '0;
    for (int i = 0; i < 6; i++) tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("ecnt_clr", edge_cnt, 24'h0);
    for (int i = 0; i < 255; i++) begin
      a[0] = ~a[0];
      tick();
    end
    for (int i = 0; i < 5; i++) tick();
    chk("ecnt_255", edge_cnt[7:0], 8'd255);
    chk("ecnt_others", edge_cnt[23:8], 16'h0);
    a[0] = ~a[0];
    for (int i = 0; i < 5; i++) tick();
    chk("ecnt_wrap", edge_cnt[7:0], 8'd0);
    a[0] = ~a[0];
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      found = changed[0];
    end
    chk("ecnt_pulse_seen", found, 1'b1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("ecnt_clr_prio", edge_cnt[7:0], 8'd0);
    tick();
    chk("ecnt_after", edge_cnt[7:0], 8'd0);
`endif

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
